ahb_protocol_checker: RTL and testbench

Synthesisable, parametrised AHB-Lite protocol checker that passively observes the manager-to-subordinate bus. It tracks every burst with a beat-counting state machine and flags protocol violations as registered per-cycle pulses plus a sticky error vector:
- HTRANS sequencing
- address increment/wrap
- control stability
- alignment
- wait-state timeout

It sits beside the subordinate in the testbench top and in emulation builds, where no SVA engine is available.

---
 rtl/ahb_chk_pkg.sv | 52 +++++
 rtl/ahb_addr_calc.sv | 44 ++++
 rtl/ahb_protocol_checker.sv | 210 +++++++++++++++++++++
 tb/tb_ahb_protocol_checker.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_chk_pkg.sv
// Shared types for the AHB-Lite protocol checker: HTRANS/HBURST encodings,
// error bit indices, FSM state constants and burst-length helpers.
package ahb_chk_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_e;

  localparam int ERR_SEQ_NO_BURST = 0;
  localparam int ERR_EARLY_TERM   = 1;
  localparam int ERR_ADDR         = 2;
  localparam int ERR_CTRL         = 3;
  localparam int ERR_ALIGN        = 4;
  localparam int ERR_TIMEOUT      = 5;
  localparam int ERR_BUSY_IDLE    = 6;
  localparam int ERR_BITS         = 7;

  typedef logic [1:0] fsm_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIXED = 2'd1;
  localparam logic [1:0] ST_UNDEF = 2'd2;

  // Beat count of a burst type; 0 means undefined length (INCR).
  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    case (burst)
      BURST_SINGLE:             return 5'd1;
      BURST_INCR:               return 5'd0;
      BURST_WRAP4, BURST_INCR4: return 5'd4;
      BURST_WRAP8, BURST_INCR8: return 5'd8;
      default:                  return 5'd16;
    endcase
  endfunction

  function automatic logic burst_is_wrap(input logic [2:0] burst);
    return (burst == BURST_WRAP4) || (burst == BURST_WRAP8) || (burst == BURST_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_addr_calc.sv
// Combinational next-beat address for an open burst, plus a flag when an
// incrementing burst steps into a different 1 KB page.
module ahb_addr_calc
  import ahb_chk_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int SIZE_WIDTH  = 3,
  parameter int BURST_WIDTH = 3
) (
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [SIZE_WIDTH-1:0]  size,
  input  logic [BURST_WIDTH-1:0] burst,
  output logic [ADDR_WIDTH-1:0]  next_addr,
  output logic                   cross_1k
);

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  is_wrap;
  logic                  page_change;

  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size;
    incr_addr = addr + bytes;
    wrap_mask = (ADDR_WIDTH'(burst_len(3'(burst))) * bytes) - ADDR_WIDTH'(1);
    is_wrap   = burst_is_wrap(3'(burst));
    if (is_wrap) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      next_addr = incr_addr;
    end
  end

  if (ADDR_WIDTH > 10) begin : g_page
    assign page_change = next_addr[ADDR_WIDTH-1:10] != addr[ADDR_WIDTH-1:10];
  end else begin : g_no_page
    assign page_change = 1'b0;
  end

  // Odd HBURST codes are the incrementing bursts (INCR, INCR4/8/16).
  assign cross_1k = burst[0] && page_change;

endmodule

// File: rtl/ahb_protocol_checker.sv
// Passive AHB-Lite protocol checker: burst-tracking FSM, per-cycle violation
// pulses, sticky vector and counters. Define AHB_CHK_COVER_EN for cov_burst.
module ahb_protocol_checker
  import ahb_chk_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TRANS_WIDTH    = 2,
  parameter int SIZE_WIDTH     = 3,
  parameter int BURST_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   HRESET,
  input  logic [TRANS_WIDTH-1:0] HTRANS,
  input  logic [BURST_WIDTH-1:0] HBURST,
  input  logic [SIZE_WIDTH-1:0]  HSIZE,
  input  logic                   HWRITE,
  input  logic [ADDR_WIDTH-1:0]  HADDR,
  input  logic                   HREADY,
  input  logic                   HRESP,
  input  logic                   clr,
  output logic [ERR_BITS-1:0]    err,
  output logic [ERR_BITS-1:0]    err_sticky,
  output logic [CNT_WIDTH-1:0]   err_cnt,
  output logic                   burst_done,
  output logic [4:0]             beat_cnt
`ifdef AHB_CHK_COVER_EN
  ,
  output logic [CNT_WIDTH-1:0]   cov_burst [0:7]
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TRANS_WIDTH-1:0] T_IDLE   = TRANS_WIDTH'(TRANS_IDLE);
  localparam logic [TRANS_WIDTH-1:0] T_BUSY   = TRANS_WIDTH'(TRANS_BUSY);
  localparam logic [TRANS_WIDTH-1:0] T_NONSEQ = TRANS_WIDTH'(TRANS_NONSEQ);
  localparam logic [TRANS_WIDTH-1:0] T_SEQ    = TRANS_WIDTH'(TRANS_SEQ);

  fsm_state_t             state_reg, state_next;
  logic [BURST_WIDTH-1:0] burst_reg, burst_next;
  logic [SIZE_WIDTH-1:0]  size_reg, size_next;
  logic                   write_reg, write_next;
  logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
  logic [4:0]             len_reg, len_next;
  logic [4:0]             beat_reg, beat_next;
  logic                   resp_seen_reg, resp_seen_next;
  logic [TMO_W-1:0]       tmo_cnt_reg, tmo_cnt_next;
  logic [ERR_BITS-1:0]    err_reg, err_next;
  logic [ERR_BITS-1:0]    sticky_reg, sticky_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                   done_reg, done_next;

  logic [ADDR_WIDTH-1:0]  exp_addr;
  logic                   cross_1k;
  logic [4:0]             nonseq_len;
  logic                   acc_nonseq, acc_seq, acc_idle, in_burst, ctrl_diff, misaligned;

  // addr_reg holds the expected address of the current beat, so one bad
  // HADDR does not cascade into errors on the following beats.
  ahb_addr_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SIZE_WIDTH (SIZE_WIDTH),
    .BURST_WIDTH(BURST_WIDTH)
  ) u_addr_calc (
    .addr     (addr_reg),
    .size     (size_reg),
    .burst    (burst_reg),
    .next_addr(exp_addr),
    .cross_1k (cross_1k)
  );

  assign nonseq_len = burst_len(3'(HBURST));
  assign acc_nonseq = HREADY && (HTRANS == T_NONSEQ);
  assign acc_seq    = HREADY && (HTRANS == T_SEQ);
  assign acc_idle   = HREADY && (HTRANS == T_IDLE);
  assign in_burst   = state_reg != ST_IDLE;
  assign ctrl_diff  = (HBURST != burst_reg) || (HSIZE != size_reg) || (HWRITE != write_reg);
  assign misaligned = (HADDR & ((ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1))) != '0;

  always_comb begin
    err_next = '0;
    err_next[ERR_SEQ_NO_BURST] = acc_seq && !in_burst;
    err_next[ERR_EARLY_TERM]   = (state_reg == ST_FIXED) && (acc_nonseq || acc_idle)
                                 && !(resp_seen_reg || HRESP);
    err_next[ERR_ADDR]         = acc_seq && in_burst && ((HADDR != exp_addr) || cross_1k);
    err_next[ERR_CTRL]         = acc_seq && in_burst && ctrl_diff;
    err_next[ERR_ALIGN]        = acc_nonseq && misaligned;
    err_next[ERR_TIMEOUT]      = !HREADY && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
    err_next[ERR_BUSY_IDLE]    = HREADY && (HTRANS == T_BUSY) && !in_burst;
  end

  // The FSM follows the normal transition even when a check fires.
  always_comb begin
    state_next     = state_reg;
    burst_next     = burst_reg;
    size_next      = size_reg;
    write_next     = write_reg;
    addr_next      = addr_reg;
    len_next       = len_reg;
    beat_next      = beat_reg;
    done_next      = 1'b0;
    resp_seen_next = resp_seen_reg || (in_burst && HRESP);
    if (acc_nonseq) begin
      burst_next     = HBURST;
      size_next      = HSIZE;
      write_next     = HWRITE;
      addr_next      = HADDR;
      len_next       = nonseq_len;
      beat_next      = 5'd1;
      resp_seen_next = 1'b0;
      if (nonseq_len == 5'd0) begin
        state_next = ST_UNDEF;
      end else if (nonseq_len == 5'd1) begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = ST_FIXED;
      end
    end else if (acc_seq && in_burst) begin
      addr_next = exp_addr;
      if (beat_reg != 5'd31) begin
        beat_next = beat_reg + 5'd1;
      end
      if ((state_reg == ST_FIXED) && (beat_next == len_reg)) begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
    end else if (acc_idle) begin
      state_next = ST_IDLE;
    end
  end

  always_comb begin
    if (HREADY) begin
      tmo_cnt_next = '0;
    end else if (tmo_cnt_reg != TMO_W'(TIMEOUT_CYCLES)) begin
      tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
    end else begin
      tmo_cnt_next = tmo_cnt_reg;
    end
    if (clr) begin
      sticky_next = err_next;
      cnt_next    = (|err_next) ? CNT_WIDTH'(1) : '0;
    end else begin
      sticky_next = sticky_reg | err_next;
      cnt_next    = ((|err_next) && (cnt_reg != '1)) ? cnt_reg + CNT_WIDTH'(1) : cnt_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (HRESET) begin
      state_reg     <= ST_IDLE;
      burst_reg     <= '0;
      size_reg      <= '0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      len_reg       <= '0;
      beat_reg      <= '0;
      resp_seen_reg <= 1'b0;
      tmo_cnt_reg   <= '0;
      err_reg       <= '0;
      sticky_reg    <= '0;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      burst_reg     <= burst_next;
      size_reg      <= size_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      len_reg       <= len_next;
      beat_reg      <= beat_next;
      resp_seen_reg <= resp_seen_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      err_reg       <= err_next;
      sticky_reg    <= sticky_next;
      cnt_reg       <= cnt_next;
      done_reg      <= done_next;
    end
  end

  assign err        = err_reg;
  assign err_sticky = sticky_reg;
  assign err_cnt    = cnt_reg;
  assign burst_done = done_reg;
  assign beat_cnt   = beat_reg;

`ifdef AHB_CHK_COVER_EN
  // SINGLE and INCR count at their NONSEQ; fixed bursts count on completion.
  for (genvar gi = 0; gi < 8; gi++) begin : g_cov
    logic                 hit;
    logic [CNT_WIDTH-1:0] cov_reg;
    if (gi < 2) begin : g_at_start
      assign hit = acc_nonseq && (3'(HBURST) == 3'(gi));
    end else begin : g_at_end
      assign hit = acc_seq && done_next && (3'(burst_reg) == 3'(gi));
    end
    always_ff @(posedge clk) begin
      if (HRESET) begin
        cov_reg <= '0;
      end else if (hit && (cov_reg != '1)) begin
        cov_reg <= cov_reg + CNT_WIDTH'(1);
      end
    end
    assign cov_burst[gi] = cov_reg;
  end
`endif

endmodule

// File: tb/tb_ahb_protocol_checker.sv
// Self-checking bench for ahb_protocol_checker: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_ahb_protocol_checker;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = 31;
  localparam int TMO     = 16;

  logic        clk;
  logic        rst;
  logic [1:0]  trans;
  logic [2:0]  burst;
  logic [2:0]  size;
  logic        write;
  logic [31:0] addr;
  logic        ready;
  logic        resp;
  logic        clr;
  logic [6:0]  err;
  logic [6:0]  err_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic        burst_done;
  logic [4:0]  beat_cnt;
`ifdef AHB_CHK_COVER_EN
  logic [CNT_W-1:0] cov_burst [0:7];
`endif

  int checks = 0;
  int passed = 0;

  // Behavioural model state
  int          m_open = 0;   // 0 no burst, 1 fixed-length, 2 undefined-length
  int          m_len = 0, m_beats = 0, m_burst = 0, m_size = 0, m_low = 0, m_cnt = 0;
  logic [31:0] m_addr = 0;
  logic        m_write = 0, m_resp = 0, m_done = 0;
  logic [6:0]  m_err = 0, m_sticky = 0;
  int          m_cov [8];

  ahb_protocol_checker #(
    .ADDR_WIDTH(32), .TRANS_WIDTH(2), .SIZE_WIDTH(3), .BURST_WIDTH(3),
    .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk), .HRESET(rst), .HTRANS(trans), .HBURST(burst), .HSIZE(size),
    .HWRITE(write), .HADDR(addr), .HREADY(ready), .HRESP(resp), .clr(clr),
    .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .burst_done(burst_done), .beat_cnt(beat_cnt)
`ifdef AHB_CHK_COVER_EN
    , .cov_burst(cov_burst)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int spec_len(int b);
    case (b)
      0: return 1;
      1: return 0;
      2, 3: return 4;
      4, 5: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] spec_next(logic [31:0] a, int s, int b);
    longint bytes, span, base;
    bytes = longint'(1) << s;
    if (b == 2 || b == 4 || b == 6) begin
      span = spec_len(b) * bytes;
      base = longint'(a) - (longint'(a) % span);
      return 32'(base + ((longint'(a) - base + bytes) % span));
    end
    return 32'(longint'(a) + bytes);
  endfunction

  task automatic model_edge();
    logic [6:0]  e;
    logic [31:0] nxt;
    e = 0;
    m_done = 0;
    nxt = spec_next(m_addr, m_size, m_burst);
    if (rst) begin
      m_open = 0; m_len = 0; m_beats = 0; m_burst = 0; m_size = 0; m_low = 0;
      m_cnt = 0; m_addr = 0; m_write = 0; m_resp = 0; m_err = 0; m_sticky = 0;
      for (int k = 0; k < 8; k++) m_cov[k] = 0;
      return;
    end
    if (ready && trans == 3 && m_open == 0) e[0] = 1;
    if (ready && (trans == 0 || trans == 2) && m_open == 1 && !(m_resp || resp)) e[1] = 1;
    if (ready && trans == 3 && m_open != 0) begin
      if (addr != nxt || (m_burst % 2 == 1 && nxt[31:10] != m_addr[31:10])) e[2] = 1;
      if (burst != 3'(m_burst) || size != 3'(m_size) || write != m_write) e[3] = 1;
    end
    if (ready && trans == 2 && (addr % (32'd1 << size)) != 0) e[4] = 1;
    if (!ready) begin
      m_low++;
      if (m_low == TMO) e[5] = 1;
    end else begin
      m_low = 0;
    end
    if (ready && trans == 1 && m_open == 0) e[6] = 1;
    if (m_open != 0 && resp) m_resp = 1;
    if (ready && trans == 2) begin
      m_burst = int'(burst); m_size = int'(size); m_write = write; m_addr = addr;
      m_resp = 0; m_beats = 1; m_len = spec_len(m_burst);
      if (m_len == 1) begin
        m_open = 0; m_done = 1;
        if (m_cov[0] < CNT_MAX) m_cov[0]++;
      end else if (m_len == 0) begin
        m_open = 2;
        if (m_cov[1] < CNT_MAX) m_cov[1]++;
      end else begin
        m_open = 1;
      end
    end else if (ready && trans == 3 && m_open != 0) begin
      m_addr = nxt;
      if (m_beats < 31) m_beats++;
      if (m_open == 1 && m_beats == m_len) begin
        m_done = 1; m_open = 0;
        if (m_cov[m_burst] < CNT_MAX) m_cov[m_burst]++;
      end
    end else if (ready && trans == 0) begin
      m_open = 0;
    end
    m_err = e;
    if (clr) begin
      m_sticky = e;
      m_cnt = (e != 0) ? 1 : 0;
    end else begin
      m_sticky |= e;
      if (e != 0 && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus(input int t, input int b, input int s, input logic [31:0] a);
    trans = 2'(t); burst = 3'(b); size = 3'(s); addr = a;
    step();
  endtask

  task automatic do_reset();
    rst = 1; trans = 0; ready = 1; resp = 0; clr = 0; write = 0;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; trans = 2'($urandom); burst = 3'($urandom); addr = $urandom;
    ready = 1; resp = 0; clr = 0;
    step(); step();
    checks++;
    if (err !== 0 || err_sticky !== 0 || err_cnt !== 0 || burst_done !== 0 || beat_cnt !== 0)
      $display("FAIL reset: err=%h sticky=%h cnt=%0d done=%b beat=%0d, expected all zero",
               err, err_sticky, err_cnt, burst_done, beat_cnt);
    else passed++;
    rst = 0; trans = 0;
  endtask

  task automatic test_incr4();
    for (int i = 0; i < 4; i++) begin
      bus(i == 0 ? 2 : 3, 3, 2, 32'h100 + 32'(4 * i));
      checks++;
      if (err !== 0 || beat_cnt !== 5'(i + 1) || burst_done !== (i == 3))
        $display("FAIL incr4_beat%0d: err=%h beat=%0d done=%b, expected err=00 beat=%0d done=%b",
                 i, err, beat_cnt, burst_done, i + 1, i == 3);
      else passed++;
    end
    bus(0, 0, 0, 0);
    checks++;
    if (err !== 0 || burst_done !== 0)
      $display("FAIL incr4_after: err=%h done=%b, expected 00/0", err, burst_done);
    else passed++;
  endtask

  task automatic test_wrap8();
    logic [31:0] beats [8];
    beats = '{32'h34, 32'h38, 32'h3C, 32'h40, 32'h24, 32'h28, 32'h2C, 32'h30};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus(i == 0 ? 2 : 3, 4, 2, beats[i]);
      checks++;
      if (err !== ((i == 3) ? 7'h04 : 7'h00) || burst_done !== (i == 7))
        $display("FAIL wrap8_beat%0d: err=%h done=%b, expected err=%h done=%b",
                 i, err, burst_done, (i == 3) ? 7'h04 : 7'h00, i == 7);
      else passed++;
    end
    checks++;
    if (err_sticky !== 7'h04 || err_cnt !== 1)
      $display("FAIL wrap8_sticky: sticky=%h cnt=%0d, expected 04/1", err_sticky, err_cnt);
    else passed++;
    bus(0, 0, 0, 0);
  endtask

  task automatic test_early_term();
    do_reset();
    bus(2, 5, 2, 32'h200); bus(3, 5, 2, 32'h204); bus(3, 5, 2, 32'h208);
    checks++;
    if (beat_cnt !== 3) $display("FAIL early_beats: beat=%0d, expected 3", beat_cnt);
    else passed++;
    bus(2, 0, 2, 32'h300);
    checks++;
    if (err !== 7'h02) $display("FAIL early_term: err=%h, expected 02", err);
    else passed++;
    bus(2, 5, 2, 32'h200);
    resp = 1; bus(3, 5, 2, 32'h204);
    resp = 0; bus(3, 5, 2, 32'h208);
    bus(2, 0, 2, 32'h300);
    checks++;
    if (err !== 7'h00) $display("FAIL early_term_resp: err=%h, expected 00", err);
    else passed++;
    bus(0, 0, 0, 0);
  endtask

  task automatic test_boundaries();
    do_reset();
    bus(2, 0, 2, 32'h102);
    checks++;
    if (err !== 7'h10 || burst_done !== 1)
      $display("FAIL align: err=%h done=%b, expected 10/1", err, burst_done);
    else passed++;
    bus(1, 0, 0, 0);
    checks++;
    if (err !== 7'h40) $display("FAIL busy_idle: err=%h, expected 40", err);
    else passed++;
    bus(2, 1, 2, 32'h3F8); bus(3, 1, 2, 32'h3FC); bus(3, 1, 2, 32'h400);
    checks++;
    if (err !== 7'h04) $display("FAIL cross_1k: err=%h, expected 04", err);
    else passed++;
    bus(0, 0, 0, 0);
    checks++;
    if (err !== 7'h00) $display("FAIL undef_idle: err=%h, expected 00", err);
    else passed++;
    bus(2, 3, 2, 32'h600);
    write = 1; bus(3, 3, 2, 32'h604);
    write = 0;
    checks++;
    if (err !== 7'h08) $display("FAIL ctrl: err=%h, expected 08", err);
    else passed++;
    bus(0, 0, 0, 0);
    checks++;
    if (err !== 7'h02) $display("FAIL ctrl_then_idle: err=%h, expected 02", err);
    else passed++;
  endtask

  task automatic test_timeout();
    int pulses, at;
    do_reset();
    trans = 0; ready = 0; pulses = 0; at = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (err[5]) begin pulses++; at = i + 1; end
    end
    ready = 1; step();
    if (err[5]) pulses++;
    checks++;
    if (pulses !== 1 || at !== 16)
      $display("FAIL timeout16: pulses=%0d at=%0d, expected 1 at 16", pulses, at);
    else passed++;
    ready = 0; pulses = 0;
    for (int i = 0; i < 15; i++) begin step(); if (err[5]) pulses++; end
    ready = 1; step();
    if (err[5]) pulses++;
    checks++;
    if (pulses !== 0) $display("FAIL timeout15: pulses=%0d, expected 0", pulses);
    else passed++;
    ready = 0; pulses = 0;
    for (int i = 0; i < 40; i++) begin step(); if (err[5]) pulses++; end
    ready = 1; step();
    if (err[5]) pulses++;
    checks++;
    if (pulses !== 1 || err_sticky !== 7'h20)
      $display("FAIL timeout40: pulses=%0d sticky=%h, expected 1/20", pulses, err_sticky);
    else passed++;
  endtask

  task automatic test_clr_collision();
    do_reset();
    bus(1, 0, 0, 0);
    bus(0, 0, 0, 0);
    clr = 1; bus(3, 0, 0, 0);
    checks++;
    if (err !== 7'h01 || err_sticky !== 7'h01 || err_cnt !== 1)
      $display("FAIL clr_collision: err=%h sticky=%h cnt=%0d, expected 01/01/1",
               err, err_sticky, err_cnt);
    else passed++;
    bus(0, 0, 0, 0);
    clr = 0;
    checks++;
    if (err_sticky !== 0 || err_cnt !== 0)
      $display("FAIL clr_only: sticky=%h cnt=%0d, expected 00/0", err_sticky, err_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus(2, 6, 2, 32'h80); bus(3, 6, 2, 32'h84); bus(3, 6, 2, 32'h88);
    rst = 1; bus(3, 6, 2, 32'h8C);
    checks++;
    if (err !== 0 || err_sticky !== 0 || err_cnt !== 0 || burst_done !== 0 || beat_cnt !== 0)
      $display("FAIL reset_mid: err=%h sticky=%h cnt=%0d done=%b beat=%0d, expected all zero",
               err, err_sticky, err_cnt, burst_done, beat_cnt);
    else passed++;
    rst = 0;
    bus(2, 3, 2, 32'h500);
    checks++;
    if (err !== 0 || beat_cnt !== 1)
      $display("FAIL reset_restart: err=%h beat=%0d, expected 00/1", err, beat_cnt);
    else passed++;
    bus(3, 3, 2, 32'h504); bus(3, 3, 2, 32'h508); bus(3, 3, 2, 32'h50C);
    checks++;
    if (err !== 0 || burst_done !== 1 || err_sticky !== 0)
      $display("FAIL reset_restart_done: err=%h done=%b sticky=%h, expected 00/1/00",
               err, burst_done, err_sticky);
    else passed++;
    bus(0, 0, 0, 0);
  endtask

`ifdef AHB_CHK_COVER_EN
  task automatic test_cover();
    int exp_cov;
    do_reset();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 4; i++)
        bus(i == 0 ? 2 : 3, 3, 2, 32'h1000 + 32'(64 * b + 4 * i));
    bus(2, 0, 2, 32'h2000);
    bus(2, 0, 2, 32'h2004);
    bus(0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      exp_cov = (k == 3) ? 3 : (k == 0) ? 2 : 0;
      checks++;
      if (cov_burst[k] !== CNT_W'(exp_cov))
        $display("FAIL cov_burst%0d: got %0d, expected %0d", k, cov_burst[k], exp_cov);
      else passed++;
    end
  endtask
`endif

  task automatic test_random();
    int r;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r     = $urandom_range(0, 99);
      ready = (n >= 1500 && n < 2000) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 80);
      resp  = $urandom_range(0, 99) < 3;
      clr   = $urandom_range(0, 99) < 3;
      rst   = $urandom_range(0, 999) < 3;
      if (m_open != 0 && r < 70) begin
        trans = 3; burst = 3'(m_burst); size = 3'(m_size); write = m_write;
        addr = spec_next(m_addr, m_size, m_burst);
        if (r < 4) addr = addr ^ 32'h4;
        if (r == 5) size = size ^ 3'd1;
      end else if (r < 85) begin
        trans = 2; burst = 3'($urandom); size = 3'($urandom_range(0, 2)); write = 1'($urandom);
        addr = ($urandom & 32'h0000_0FFF) & ~((32'd1 << size) - 32'd1);
        if (r == 84) addr = addr | 32'h1;
      end else if (r < 92) begin
        trans = 0;
      end else if (r < 96) begin
        trans = 1;
      end else begin
        trans = 3; addr = $urandom & 32'h0000_0FFF;
      end
      step();
      checks++;
      if (err !== m_err || burst_done !== m_done || beat_cnt !== 5'(m_beats) ||
          err_sticky !== m_sticky || err_cnt !== CNT_W'(m_cnt))
        $display("FAIL random_cycle%0d: err=%h done=%b beat=%0d sticky=%h cnt=%0d, expected err=%h done=%b beat=%0d sticky=%h cnt=%0d",
                 n, err, burst_done, beat_cnt, err_sticky, err_cnt,
                 m_err, m_done, m_beats, m_sticky, m_cnt);
      else passed++;
    end
`ifdef AHB_CHK_COVER_EN
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cov_burst[k] !== CNT_W'(m_cov[k]))
        $display("FAIL random_cov%0d: got %0d, expected %0d", k, cov_burst[k], m_cov[k]);
      else passed++;
    end
`endif
    rst = 0; clr = 0; resp = 0; ready = 1; trans = 0;
  endtask

  initial begin
    rst = 1; trans = 0; burst = 0; size = 0; write = 0; addr = 0;
    ready = 1; resp = 0; clr = 0;
    for (int k = 0; k < 8; k++) m_cov[k] = 0;
    test_reset();
    test_incr4();
    test_wrap8();
    test_early_term();
    test_boundaries();
    test_timeout();
    test_clr_collision();
    test_reset_mid_burst();
`ifdef AHB_CHK_COVER_EN
    test_cover();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
